// File: rtl/rcservo_pkg.sv
// Shared types and constants for the RC-servo pulse decoder.
// Optional pulse range rejection in rcservo_decode is enabled by RCSERVO_RANGE_CHECK_EN.
package rcservo_pkg;

    localparam int unsigned W_BITS = 12;
    localparam int unsigned F_BITS = 13;

    localparam logic [W_BITS-1:0] W_ZERO   = 12'd256;
    localparam logic [W_BITS-1:0] W_FULL   = 12'd511;
    localparam logic [W_BITS-1:0] W_SAT    = 12'd4095;
    localparam logic [W_BITS-1:0] W_REJ_LO = 12'd192;
    localparam logic [W_BITS-1:0] W_REJ_HI = 12'd575;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2
    } state_t;

    // Map a width in ticks onto the 0..255 position scale, saturating both ends.
    function automatic logic [7:0] w_to_pos(input logic [W_BITS-1:0] w);
        if (w < W_ZERO) begin
            return '0;
        end else if (w > W_FULL) begin
            return '1;
        end else begin
            return w[7:0];
        end
    endfunction

endpackage

// File: rtl/rcservo_tick.sv
// Free-running prescaler: one-clk tick every ClkDiv cycles, never restarted by the input.
module rcservo_tick #(
    parameter int unsigned ClkDiv = 98
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(ClkDiv - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rcservo_decode.sv
// RC-servo pulse decoder: measures high time in ticks, converts to 8-bit position, flags loss.
// Define RCSERVO_RANGE_CHECK_EN to reject out-of-range pulses and add the err strobe.
module rcservo_decode
    import rcservo_pkg::*;
#(
    parameter int unsigned ClkDiv       = 98,
    parameter int unsigned TimeoutTicks = 8191
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic [7:0] pos,
    output logic       valid,
    output logic       lost
`ifdef RCSERVO_RANGE_CHECK_EN
    ,
    output logic       err
`endif
);

    localparam logic [F_BITS-1:0] F_SAT = F_BITS'(TimeoutTicks);

    logic              s1, s2, s3;
    logic              rise, fall;
    logic              tick;
    logic [1:0]        settle;
    state_t            state, state_nx;
    logic [W_BITS-1:0] w;
    logic [F_BITS-1:0] f;
    logic              load_w, inc_w, done;
    logic              range_bad, rej, accept;

    rcservo_tick #(.ClkDiv(ClkDiv)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

`ifdef RCSERVO_RANGE_CHECK_EN
    assign range_bad = (w < W_REJ_LO) || (w > W_REJ_HI);
`else
    assign range_bad = 1'b0;
`endif
    assign rej    = done & range_bad;
    assign accept = done & ~range_bad;
    assign lost   = (f == F_SAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARM;
        end else begin
            state <= state_nx;
        end
    end

    // The synchronizer holds reset zeros for its first cycles; ARM only trusts s2 once settle saturates.
    always_comb begin
        state_nx = state;
        load_w   = 1'b0;
        inc_w    = 1'b0;
        done     = 1'b0;
        case (state)
            ARM: begin
                if ((settle == 2'd3) && !s2) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    load_w   = 1'b1;
                    state_nx = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (w == W_SAT) begin
                    state_nx = ARM;
                end else if (tick) begin
                    inc_w = 1'b1;
                end
            end
            default: state_nx = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            settle <= '0;
            w      <= '0;
            f      <= F_SAT;
            pos    <= '0;
            valid  <= 1'b0;
        end else begin
            s1    <= in;
            s2    <= s1;
            s3    <= s2;
            valid <= accept;
            if (settle != 2'd3) begin
                settle <= settle + 1'b1;
            end
            if (load_w) begin
                w <= '0;
            end else if (inc_w) begin
                w <= w + 1'b1;
            end
            if (accept) begin
                pos <= w_to_pos(w);
            end
            if (accept) begin
                f <= '0;
            end else if (tick && (f != F_SAT)) begin
                f <= f + 1'b1;
            end
        end
    end

`ifdef RCSERVO_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= rej;
        end
    end
`else
    logic rej_unused;
    assign rej_unused = rej;
`endif

endmodule

// File: tb/tb_rcservo_decode.sv
// Self-checking bench for rcservo_decode with ClkDiv=4 against a tick-counting reference model.
module tb_rcservo_decode;
    import rcservo_pkg::*;

    localparam int unsigned D  = 4;
    localparam int unsigned TO = 8191;

    logic       clk;
    logic       rst;
    logic       in;
    logic [7:0] pos;
    logic       valid;
    logic       lost;
`ifdef RCSERVO_RANGE_CHECK_EN
    logic       err;
`endif

    rcservo_decode #(.ClkDiv(D), .TimeoutTicks(TO)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .pos   (pos),
        .valid (valid),
        .lost  (lost)
`ifdef RCSERVO_RANGE_CHECK_EN
        ,
        .err   (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  pos;
        logic        lost;
    } ev_t;

    int unsigned cyc;
    logic        rst_q;
    ev_t         vq[$];
    int unsigned eq[$];
    int unsigned pos_glitch;
    logic [7:0]  pos_prev;
    int          n_vec;
    int          n_err;
    logic [7:0]  exp_pos;

    // Cycle index since the last reset edge; the prescaler ticks when cyc % D == D-1.
    always @(posedge clk) begin
        rst_q <= rst;
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        ev_t e;
        if (valid === 1'b1) begin
            e.cyc  = cyc;
            e.pos  = pos;
            e.lost = lost;
            vq.push_back(e);
        end
`ifdef RCSERVO_RANGE_CHECK_EN
        if (err === 1'b1) eq.push_back(cyc);
`endif
        if (rst_q === 1'b0 && valid !== 1'b1 && pos !== pos_prev) pos_glitch++;
        pos_prev = pos;
    end

    function automatic int unsigned model_w(input int unsigned cr, input int unsigned cf);
        int unsigned n;
        n = 0;
        for (int unsigned c = cr + 3; c <= cf + 1; c++) begin
            if (c % D == D - 1) n++;
        end
        return (n > 4095) ? 4095 : n;
    endfunction

    function automatic logic [7:0] model_pos(input int unsigned w);
        if (w < 256) return 8'd0;
        if (w > 511) return 8'd255;
        return 8'(w - 256);
    endfunction

    function automatic logic model_rej(input int unsigned w);
`ifdef RCSERVO_RANGE_CHECK_EN
        return (w < 192) || (w > 575);
`else
        return (w > 4095);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_pulse(input string tag, input int unsigned hi, input int unsigned lo,
                            input bit align);
        int unsigned cr, cf, nv, ne, wm;
        logic [7:0]  p;
        nv = vq.size();
        ne = eq.size();
        @(negedge clk);
        if (align) begin
            for (int k = 0; k < int'(D) && ((cyc + 2) % D != D - 1); k++) @(negedge clk);
        end
        in = 1'b1;
        cr = cyc;
        repeat (hi) @(negedge clk);
        in = 1'b0;
        cf = cyc;
        repeat (lo) @(negedge clk);
        wm = model_w(cr, cf);
        p  = model_pos(wm);
        if (!model_rej(wm)) begin
            check({tag, "_nvalid"}, 32'(vq.size()), 32'(nv + 1));
            check({tag, "_nerr"}, 32'(eq.size()), 32'(ne));
            if (vq.size() == nv + 1) begin
                check({tag, "_vcyc"}, vq[nv].cyc, cf + 3);
                check({tag, "_vpos"}, 32'(vq[nv].pos), 32'(p));
                check({tag, "_vlost"}, 32'(vq[nv].lost), 32'd0);
            end
            exp_pos = p;
        end else begin
            check({tag, "_nvalid"}, 32'(vq.size()), 32'(nv));
            check({tag, "_nerr"}, 32'(eq.size()), 32'(ne + 1));
            if (eq.size() == ne + 1) check({tag, "_ecyc"}, eq[ne], cf + 3);
        end
        check({tag, "_pos"}, 32'(pos), 32'(exp_pos));
    endtask

    initial begin
        int unsigned lv, nv, hi, lo;
        n_vec      = 0;
        n_err      = 0;
        pos_glitch = 0;
        pos_prev   = '0;
        exp_pos    = '0;
        rst        = 1'b1;
        in         = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_lost", 32'(lost), 32'd1);
`ifdef RCSERVO_RANGE_CHECK_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        rst = 1'b0;

        // Input already high out of reset: that partial pulse must be ignored.
        repeat (2000) @(negedge clk);
        in = 1'b0;
        repeat (20) @(negedge clk);
        check("partial_nvalid", 32'(vq.size()), 32'd0);
        check("partial_lost", 32'(lost), 32'd1);

        do_pulse("p1536", 1536, 20, 1'b0);
        check("p1536_mid", 32'(pos == 8'd127 || pos == 8'd128), 32'd1);
        check("p1536_lost", 32'(lost), 32'd0);
        do_pulse("p1024", 1024, 20, 1'b0);
        check("p1024_zero", 32'(pos), 32'd0);
        do_pulse("p2048", 2048, 20, 1'b0);
        check("p2048_top", 32'(pos == 8'd254 || pos == 8'd255), 32'd1);
        do_pulse("p3000", 3000, 20, 1'b0);
`ifndef RCSERVO_RANGE_CHECK_EN
        check("p3000_sat", 32'(pos), 32'd255);
`endif

        // Stuck high: no decode, abort to ARM, timeout counted from the last valid.
        lv = (vq.size() > 0) ? vq[vq.size() - 1].cyc : 0;
        nv = vq.size();
        in = 1'b1;
        repeat (20000) @(negedge clk);
        check("stuck_nvalid", 32'(vq.size()), 32'(nv));
        check("stuck_arm", 32'(dut.state === ARM), 32'd1);
        in = 1'b0;
        while (cyc < lv + 32755) @(negedge clk);
        check("lost_before", 32'(lost), 32'd0);
        while (cyc < lv + 32770) @(negedge clk);
        check("lost_after", 32'(lost), 32'd1);
        do_pulse("p_after_stuck", 1536, 20, 1'b0);
        check("after_stuck_lost", 32'(lost), 32'd0);

        // Reset mid-pulse discards the pulse and restores reset outputs.
        nv = vq.size();
        @(negedge clk);
        in = 1'b1;
        repeat (768) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_pos", 32'(pos), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_lost", 32'(lost), 32'd1);
`ifdef RCSERVO_RANGE_CHECK_EN
        check("midrst_err", 32'(err), 32'd0);
`endif
        exp_pos = '0;
        repeat (767) @(negedge clk);
        in = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_nvalid", 32'(vq.size()), 32'(nv));
        do_pulse("p_after_rst", 1536, 20, 1'b0);
        check("after_rst_mid", 32'(pos == 8'd127 || pos == 8'd128), 32'd1);

        // Random widths and phases; even pulses place rise on a tick cycle.
        for (int i = 0; i < 50; i++) begin
            hi = $urandom_range(2400, 800);
            lo = $urandom_range(40, 8);
            if (i % 2 != 0) repeat ($urandom_range(3, 0)) @(negedge clk);
            do_pulse($sformatf("rnd%0d", i), hi, lo, (i % 2 == 0));
        end

        check("pos_stable", pos_glitch, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
